// File: rtl/reg_scoreboard_pkg.sv
// Shared encodings for the GPR scoreboard: destination latency
// classes, stall causes and the architectural register count.
package reg_scoreboard_pkg;

    localparam int NUM_GPR = 32;

    typedef enum logic [1:0] {
        WC_ALU  = 2'd0,
        WC_LOAD = 2'd1,
        WC_LONG = 2'd2,
        WC_RSVD = 2'd3
    } wr_class_e;

    typedef enum logic [1:0] {
        SC_NONE     = 2'd0,
        SC_LOAD_USE = 2'd1,
        SC_LONG_RAW = 2'd2,
        SC_MDU      = 2'd3
    } stall_cause_e;

endpackage

// File: rtl/sb_cnt_cell.sv
// Per-register load countdown: load, clear, decrement-when-running.
// A nonzero count means the register result is not yet forwardable.
module sb_cnt_cell
    import reg_scoreboard_pkg::*;
#(
    parameter int CW       = 1,
    parameter int LOAD_VAL = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic load_i,
    input  logic zero_i,
    input  logic hold_i,
    output logic busy_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // An issue write wins over the decrement of the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CW'(LOAD_VAL);
        end else if (zero_i) begin
            cnt_d = '0;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// GPR scoreboard for the ID stage: load-use countdowns per register
// plus a single outstanding long (MULT/DIV) destination.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int REG_NUM  = NUM_GPR,
    parameter int LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_read_en_1,
    input  logic [4:0]         reg_addr_1,
    input  logic               reg_read_en_2,
    input  logic [4:0]         reg_addr_2,
    input  logic               reg_write_en,
    input  logic [4:0]         reg_write_addr,
    input  logic               issue_valid,
    input  logic [1:0]         wr_class,
    input  logic               stall_ext,
    input  logic               flush,
    input  logic               long_done,
    output logic               stall_req,
    output logic [1:0]         stall_cause,
    output logic [REG_NUM-1:0] busy_mask,
    output logic               mdu_cancel
);

    localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    wr_class_e          cls;
    logic [REG_NUM-1:0] cnt_busy;
    logic               long_busy_q;
    logic               long_busy_d;
    logic [4:0]         long_addr_q;
    logic [4:0]         long_addr_d;
    logic               mdu_cancel_q;
    logic               mdu_cancel_d;
    logic               rd1;
    logic               rd2;
    logic               haz_load;
    logic               haz_long;
    logic               haz_mdu;
    logic               issue;
    logic               wr_ok;
    logic               load_set;
    logic               alu_clr;
    logic               long_set;

    assign cls = wr_class_e'(wr_class);
    assign rd1 = reg_read_en_1 && (reg_addr_1 != 5'd0);
    assign rd2 = reg_read_en_2 && (reg_addr_2 != 5'd0);

    assign haz_load = (rd1 && cnt_busy[reg_addr_1])
                   || (rd2 && cnt_busy[reg_addr_2]);

    // long_addr is never r0, so a write-enable to r0 cannot match it.
    assign haz_long = long_busy_q
                   && ((rd1 && (reg_addr_1 == long_addr_q))
                    || (rd2 && (reg_addr_2 == long_addr_q))
                    || (reg_write_en && (reg_write_addr == long_addr_q)));

    assign haz_mdu = (cls == WC_LONG) && long_busy_q;

    always_comb begin
        stall_req   = 1'b0;
        stall_cause = SC_NONE;
        if (issue_valid) begin
            if (haz_long) begin
                stall_req   = 1'b1;
                stall_cause = SC_LONG_RAW;
            end else if (haz_load) begin
                stall_req   = 1'b1;
                stall_cause = SC_LOAD_USE;
            end else if (haz_mdu) begin
                stall_req   = 1'b1;
                stall_cause = SC_MDU;
            end
        end
    end

    assign issue    = issue_valid && !stall_req && !stall_ext && !flush;
    assign wr_ok    = issue && reg_write_en && (reg_write_addr != 5'd0);
    assign load_set = wr_ok && (cls == WC_LOAD);
    assign alu_clr  = wr_ok && ((cls == WC_ALU) || (cls == WC_RSVD));
    assign long_set = wr_ok && (cls == WC_LONG);

    assign cnt_busy[0] = 1'b0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cell
        logic hit;
        assign hit = (reg_write_addr == 5'(r));
        sb_cnt_cell #(
            .CW       (CW),
            .LOAD_VAL (LOAD_LAT)
        ) u_cell (
            .clk_i  (clk),
            .rst_i  (rst),
            .clr_i  (flush),
            .load_i (load_set && hit),
            .zero_i (alu_clr && hit),
            .hold_i (stall_ext),
            .busy_o (cnt_busy[r])
        );
    end

    always_comb begin
        long_busy_d  = long_busy_q;
        long_addr_d  = long_addr_q;
        mdu_cancel_d = 1'b0;
        if (flush) begin
            long_busy_d  = 1'b0;
            mdu_cancel_d = long_busy_q;
        end else if (long_set) begin
            long_busy_d = 1'b1;
            long_addr_d = reg_write_addr;
        end else if (long_done) begin
            long_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_busy_q  <= 1'b0;
            long_addr_q  <= 5'd0;
            mdu_cancel_q <= 1'b0;
        end else begin
            long_busy_q  <= long_busy_d;
            long_addr_q  <= long_addr_d;
            mdu_cancel_q <= mdu_cancel_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            busy_mask[r] = cnt_busy[r]
                        || (long_busy_q && (long_addr_q == 5'(r)));
        end
    end

    assign mdu_cancel = mdu_cancel_q;

endmodule
